// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and boot image for the instruction memory.
// The boot image is only written into memory when IMEM_BOOT_IMAGE_EN is defined.
package imem_pkg;

  localparam int IMEM_ADDR_W = 5;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  localparam int BOOT_LEN = 3;
  localparam logic [BOOT_LEN-1:0][31:0] BOOT_IMAGE = {32'h00221820, 32'h3402000C, 32'h20010008};

  // Boot word for a given word index; zero beyond the end of the image
  function automatic logic [31:0] boot_word(input logic [31:0] idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    for (int i = 0; i < BOOT_LEN; i++) begin
      w = (idx == 32'(i)) ? BOOT_IMAGE[i[1:0]] : w;
    end
    return w;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port and one synchronous
// read-first read port (a same-edge write is not seen by the read).
module imem_ram
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] rdata_r;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port; the output register is cleared so no X leaves after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_seq.sv
// Instruction memory with an INIT sweep after reset, a 1-cycle fetch port with
// valid/ready result holding, and a program write port. Macro: IMEM_BOOT_IMAGE_EN.
module instr_mem_seq
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic              fetch_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  imem_state_e       state_r;
  logic [ADDR_W-1:0] init_cnt_r;
  logic              instr_valid_r;
  logic              fetch_err_r;
  logic              init_done_r;

  logic              fetch_ready_s;
  logic              addr_err_s;
  logic              accept_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] init_data_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign fetch_ready_s = (state_r == ST_RUN) && (!instr_valid_r || instr_ready);
  assign addr_err_s    = (|fetch_addr[1:0]) || (|fetch_addr[31:ADDR_W+2]);
  assign accept_s      = fetch_req && fetch_ready_s;

`ifdef IMEM_BOOT_IMAGE_EN
  assign init_data_s = DATA_W'(boot_word(32'(init_cnt_r)));
`else
  assign init_data_s = {DATA_W{1'b0}};
`endif

  // Write port owner: the INIT sweep, otherwise the program port
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = init_cnt_r;
    ram_wdata_s = init_data_s;
    case (state_r)
      ST_INIT: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = init_cnt_r;
        ram_wdata_s = init_data_s;
      end
      ST_RUN: begin
        ram_we_s    = prog_we;
        ram_waddr_s = prog_addr;
        ram_wdata_s = prog_data;
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_waddr_s = init_cnt_r;
        ram_wdata_s = init_data_s;
      end
    endcase
  end

  imem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we_s),
    .waddr(ram_waddr_s),
    .wdata(ram_wdata_s),
    .re   (accept_s && !addr_err_s),
    .raddr(fetch_addr[ADDR_W+1:2]),
    .rdata(ram_rdata_s)
  );

  // INIT/RUN sequencing and the result handshake state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_INIT;
      init_cnt_r    <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
      init_done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + ADDR_W'(1);
          if (init_cnt_r == LAST_IDX) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            state_r     <= ST_INIT;
            init_done_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            instr_valid_r <= 1'b1;
            fetch_err_r   <= addr_err_s;
          end else if (instr_ready) begin
            instr_valid_r <= 1'b0;
          end else begin
            instr_valid_r <= instr_valid_r;
          end
        end
        default: begin
          state_r       <= ST_INIT;
          init_cnt_r    <= {ADDR_W{1'b0}};
          instr_valid_r <= 1'b0;
          fetch_err_r   <= 1'b0;
          init_done_r   <= 1'b0;
        end
      endcase
    end
  end

  // Error results carry a zero instruction regardless of the RAM output
  assign instr       = fetch_err_r ? {DATA_W{1'b0}} : ram_rdata_s;
  assign fetch_err   = fetch_err_r;
  assign instr_valid = instr_valid_r;
  assign init_done   = init_done_r;
  assign fetch_ready = fetch_ready_s;

endmodule

// File: tb/tb_instr_mem_seq.sv
// Self-checking bench for instr_mem_seq against a word-array reference model.
module tb_instr_mem_seq;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        fetch_err;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;
  logic        init_done;

  int n_checks;
  int n_errors;

  // reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_valid;
  bit          m_err;
  logic [31:0] m_instr;
  int          m_init_left;

  instr_mem_seq dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .fetch_err(fetch_err), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] boot_val(input int i);
`ifdef IMEM_BOOT_IMAGE_EN
    if (i == 0) return 32'h20010008;
    if (i == 1) return 32'h3402000C;
    if (i == 2) return 32'h00221820;
`endif
    return 32'h0;
  endfunction

  function automatic bit exp_ready();
    return (m_init_left == 0) && (!m_valid || instr_ready);
  endfunction

  // One clock: the model consumes the inputs held across the edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_init_left = DEPTH;
      m_valid = 1'b0; m_err = 1'b0; m_instr = 32'h0;
    end else if (m_init_left > 0) begin
      m_mem[DEPTH - m_init_left] = boot_val(DEPTH - m_init_left);
      m_init_left--;
    end else begin
      if (fetch_req && (!m_valid || instr_ready)) begin
        m_valid = 1'b1;
        if ((fetch_addr % 4 != 0) || (fetch_addr >= 4 * DEPTH)) begin
          m_err = 1'b1; m_instr = 32'h0;
        end else begin
          m_err = 1'b0; m_instr = m_mem[fetch_addr / 4];
        end
      end else if (instr_ready) begin
        m_valid = 1'b0;
      end
      if (prog_we) m_mem[prog_addr] = prog_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0; instr_ready = 1'b1;
    prog_we = 1'b0; prog_addr = 5'd0; prog_data = 32'h0;
    tick(); tick();
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || fetch_err !== 1'b0 ||
        fetch_ready !== 1'b0 || init_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: valid=%b instr=%h err=%b rdy=%b done=%b, need all 0",
               instr_valid, instr, fetch_err, fetch_ready, init_done);
    end
  endtask

  // Release reset with fetch_req high; INIT lasts exactly DEPTH cycles
  task automatic test_init();
    int bad_cycles;
    bad_cycles = 0;
    rst_n = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h4; instr_ready = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      n_checks++;
      if (fetch_ready !== 1'b0 || init_done !== 1'b0) begin
        n_errors++;
        $display("FAIL init_busy: cycle %0d rdy=%b done=%b, need 0/0", c, fetch_ready, init_done);
      end
      tick();
    end
    #1;
    n_checks++;
    if (init_done !== 1'b1 || fetch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL init_done: rdy=%b done=%b at cycle 32, need 1/1", fetch_ready, init_done);
    end
    tick();
    fetch_req = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || fetch_err !== 1'b0 || instr !== m_instr) begin
      n_errors++;
      $display("FAIL first_fetch: valid=%b err=%b instr=%h, need 1/0/%h", instr_valid, fetch_err, instr, m_instr);
    end
`ifdef IMEM_BOOT_IMAGE_EN
    n_checks++;
    if (instr !== 32'h3402000C) begin
      n_errors++;
      $display("FAIL boot_word1: instr=%h, need 3402000c", instr);
    end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    addrs[0] = 32'h6; addrs[1] = 32'h80; addrs[2] = 32'h8000_0000;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = addrs[i];
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || fetch_err !== 1'b1 || instr !== 32'h0) begin
        n_errors++;
        $display("FAIL addr_err: addr=%h valid=%b err=%b instr=%h, need 1/1/0",
                 addrs[i], instr_valid, fetch_err, instr);
      end
    end
    fetch_req = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL valid_clear: valid=%b, need 0", instr_valid);
    end
  endtask

  task automatic test_read_first();
    fetch_req = 1'b1; fetch_addr = 32'hC; instr_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 5'd3; prog_data = 32'hDEADBEEF;
    tick();
    prog_we = 1'b0;
    n_checks++;
    if (instr !== 32'h0 || fetch_err !== 1'b0 || instr !== m_instr) begin
      n_errors++;
      $display("FAIL read_first_old: instr=%h err=%b, need 00000000/0", instr, fetch_err);
    end
    tick();
    fetch_req = 1'b0;
    n_checks++;
    if (instr !== 32'hDEADBEEF || instr_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL read_first_new: instr=%h valid=%b, need deadbeef/1", instr, instr_valid);
    end
    tick();
  endtask

  // Result holds for 3 stalled cycles, then handshake plus new fetch together
  task automatic test_stall();
    logic [31:0] held;
    fetch_req = 1'b1; fetch_addr = 32'hC; instr_ready = 1'b1;
    tick();
    held = instr;
    instr_ready = 1'b0; fetch_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (fetch_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_ready: rdy=%b, need 0", fetch_ready);
      end
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== held || instr !== 32'hDEADBEEF || fetch_err !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold: valid=%b instr=%h err=%b, need 1/deadbeef/0", instr_valid, instr, fetch_err);
      end
    end
    instr_ready = 1'b1;
    #1;
    n_checks++;
    if (fetch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release: rdy=%b, need 1", fetch_ready);
    end
    tick();
    fetch_req = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== m_instr || instr !== boot_val(0)) begin
      n_errors++;
      $display("FAIL stall_next: valid=%b instr=%h, need 1/%h", instr_valid, instr, m_instr);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      fetch_req   = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       fetch_addr = {$urandom_range(0, 31), 2'b00} | 32'($urandom_range(1, 3));
        1:       fetch_addr = 32'h80 << $urandom_range(0, 24);
        default: fetch_addr = 32'($urandom_range(0, 31)) << 2;
      endcase
      prog_we   = ($urandom_range(0, 2) == 0);
      prog_addr = 5'($urandom_range(0, 31));
      prog_data = $urandom;
      #1;
      n_checks++;
      if (fetch_ready !== exp_ready()) begin
        n_errors++;
        $display("FAIL rand_ready: cycle %0d rdy=%b, need %b", c, fetch_ready, exp_ready());
      end
      tick();
      n_checks++;
      if (instr_valid !== m_valid ||
          (m_valid && (instr !== m_instr || fetch_err !== m_err))) begin
        n_errors++;
        $display("FAIL rand_result: cycle %0d valid=%b instr=%h err=%b, need %b/%h/%b",
                 c, instr_valid, instr, fetch_err, m_valid, m_instr, m_err);
      end
    end
    prog_we = 1'b0;
  endtask

  // Reset with a pending result, then confirm a programmed word is reinitialised
  task automatic test_reset_run();
    fetch_req = 1'b0; instr_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 5'd5; prog_data = 32'hCAFEF00D;
    tick();
    prog_we = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h14;
    tick();
    fetch_req = 1'b0; instr_ready = 1'b0;
    n_checks++;
    if (instr !== 32'hCAFEF00D || instr_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL prog_word5: instr=%h valid=%b, need cafef00d/1", instr, instr_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (instr_valid !== 1'b0 || init_done !== 1'b0 || fetch_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: valid=%b done=%b rdy=%b, need 0/0/0", instr_valid, init_done, fetch_ready);
    end
    instr_ready = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h14;
    for (int c = 0; c < DEPTH; c++) tick();
    n_checks++;
    if (init_done !== 1'b1) begin
      n_errors++;
      $display("FAIL reinit_done: done=%b, need 1", init_done);
    end
    tick();
    fetch_req = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0 || instr !== m_instr) begin
      n_errors++;
      $display("FAIL reinit_word5: valid=%b instr=%h, need 1/00000000", instr_valid, instr);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_init_left = DEPTH;
    m_valid = 1'b0; m_err = 1'b0; m_instr = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    #2;
    test_reset();
    test_init();
    test_errors();
    test_read_first();
    test_stall();
    test_random();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_seq.md
INSTR_MEM_SEQ -- requirements
Module: instr_mem_seq

Interface
REQ-001 Parameter ADDR_W, default 5, word-index width; depth = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 fetch_req  in  1  fetch request, qualified by fetch_ready.
REQ-006 fetch_addr  in  32  byte address of requested instruction.
REQ-007 fetch_ready  out  1  block accepts a fetch this cycle.
REQ-008 instr_valid  out  1  instr/fetch_err hold a fetch result.
REQ-009 instr_ready  in  1  consumer accepts the result.
REQ-010 instr  out  DATA_W  fetched instruction.
REQ-011 fetch_err  out  1  result is an error: misaligned or out of range.
REQ-012 prog_we  in  1  program-port write strobe.
REQ-013 prog_addr  in  ADDR_W  word index for the program write.
REQ-014 prog_data  in  DATA_W  program write data.
REQ-015 init_done  out  1  memory initialisation complete.

Function
REQ-016 Two-state FSM: INIT, RUN; INIT walks an ADDR_W-bit counter from 0 to depth-1, writing one word per cycle, then enters RUN.
REQ-017 INIT duration is exactly depth cycles after reset release; init_done rises in the cycle RUN is entered.
REQ-018 In INIT, fetch_ready = 0 and prog_we is ignored.
REQ-019 In RUN, fetch_ready = !instr_valid || instr_ready.
REQ-020 Fetch accepted when fetch_req && fetch_ready; result appears with instr_valid = 1 on the next cycle (latency 1).
REQ-021 Word index = fetch_addr[ADDR_W+1:2].
REQ-022 fetch_addr[1:0] != 0 -> fetch_err = 1, instr = 0.
REQ-023 Any bit of fetch_addr[31:ADDR_W+2] set -> fetch_err = 1, instr = 0.
REQ-024 While instr_valid && !instr_ready, instr, fetch_err and instr_valid hold unchanged.
REQ-025 instr_valid clears the cycle after a handshake with no new fetch accepted.
REQ-026 Back-to-back accepted fetches yield one result per cycle.
REQ-027 In RUN, prog_we writes prog_data to word prog_addr at the clock edge.
REQ-028 prog_we to the same word as a fetch accepted that cycle: fetch returns the old content (read-first); the new content is visible from the next fetch.
REQ-029 No X may appear on any output after reset; unwritten words read as 0.

Reset
REQ-030 rst_n = 0 -> next cycle: state INIT, init counter 0, instr_valid 0, instr 0, fetch_err 0, fetch_ready 0, init_done 0.
REQ-031 Reset asserted mid-INIT or mid-RUN restarts the full INIT sequence and discards any pending result.

Configuration
REQ-032 Macro IMEM_BOOT_IMAGE_EN defined: INIT writes the boot image constant from the package, word by word; words beyond the image length are written 0.
REQ-033 Macro IMEM_BOOT_IMAGE_EN undefined: INIT writes 0 to every word; the program is loaded only via the program port.

Structure
REQ-034 Package imem_pkg holds: default ADDR_W/DATA_W constants, FSM state typedef, boot image length constant, boot image array constant.
REQ-035 Boot image contents (default build): word 0 = 0x20010008, word 1 = 0x3402000C, word 2 = 0x00221820; length 3.
REQ-036 Storage array is a sub-module imem_ram: one synchronous write port, one synchronous read-first read port.

Verification
REQ-037 Reset release, fetch_req held high from cycle 0 -> fetch_ready = 0 for 32 cycles; init_done rises at cycle 32; first fetch accepted then.
REQ-038 BOOT_EN build, fetch addr 0x4 -> next cycle instr = 0x3402000C, instr_valid = 1, fetch_err = 0.
REQ-039 Fetch 0x6 -> fetch_err = 1, instr = 0; fetch 0x80 with ADDR_W = 5 -> fetch_err = 1.
REQ-040 prog_we to word 3 with 0xDEADBEEF while fetching 0xC -> returns 0; next fetch of 0xC returns 0xDEADBEEF.
REQ-041 Fetch accepted, instr_ready = 0 for 3 cycles -> instr stable, fetch_ready = 0; instr_ready = 1 -> handshake; next fetch accepted same cycle.
REQ-042 rst_n pulsed low during RUN with a result pending -> instr_valid = 0 next cycle; INIT repeats; previously programmed words reinitialised.
